// File: rtl/playback_pkg.sv
// Shared types for the playback control stage.
// State encodings are visible on o_state, so they are fixed here.
package playback_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 3'd0,
        S_PLAY   = 3'd1,
        S_PAUSE  = 3'd2,
        S_DONE   = 3'd3,
        S_REWIND = 3'd4
    } playback_state_t;

endpackage

// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-FF synchronizer, debounce counter and
// a single-cycle press pulse on the debounced rising edge.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = i_btn;
        sync2_d = sync1_q;
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        // Counter only runs while the synchronized input disagrees.
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_level = level_q;
    assign o_press = press_q;

endmodule

// File: rtl/playback_ctrl.sv
// Playback state machine driving the BRAM address counter's
// count-enable and clear inputs from three conditioned buttons.
import playback_pkg::*;

module playback_ctrl #(
    parameter int ADDR_WIDTH      = 13,
    parameter int LAST_ADDR       = 2**ADDR_WIDTH - 1,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  i_reset,
    input  logic                  i_btn_play,
    input  logic                  i_btn_stop,
    input  logic                  i_btn_rewind,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  o_count_go,
    output logic                  o_reset_counter,
    output logic [STATE_W-1:0]    o_state,
    output logic                  o_done
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LAST_ADDR);

    logic [2:0]      btn_level;
    logic            play_p, stop_p, rew_p;
    logic            at_last;
    playback_state_t state_q, state_d;
    logic            done_q, done_d;

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_play (
        .clk     (clk),
        .i_reset (i_reset),
        .i_btn   (i_btn_play),
        .o_level (btn_level[0]),
        .o_press (play_p)
    );

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stop (
        .clk     (clk),
        .i_reset (i_reset),
        .i_btn   (i_btn_stop),
        .o_level (btn_level[1]),
        .o_press (stop_p)
    );

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rewind (
        .clk     (clk),
        .i_reset (i_reset),
        .i_btn   (i_btn_rewind),
        .o_level (btn_level[2]),
        .o_press (rew_p)
    );

    assign at_last = (i_addr == LAST);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (rew_p)       state_d = S_REWIND;
                else if (play_p) state_d = S_PLAY;
            end
            S_PLAY: begin
                if (rew_p)        state_d = S_REWIND;
                else if (stop_p)  state_d = S_PAUSE;
                else if (at_last) state_d = S_DONE;
            end
            S_PAUSE: begin
                if (rew_p)       state_d = S_REWIND;
                else if (play_p) state_d = S_PLAY;
            end
            S_DONE: begin
                if (rew_p) state_d = S_REWIND;
            end
            S_REWIND: begin
                // Held until the counter shows the clear has landed.
                if (i_addr == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        done_d = (state_q == S_PLAY) && (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    assign o_count_go      = (state_q == S_PLAY) && !at_last;
    assign o_reset_counter = (state_q == S_REWIND);
    assign o_state         = state_q;
    assign o_done          = done_q;

endmodule

// File: tb/tb_playback_ctrl.sv
// Directed bench for playback_ctrl with a slow behavioural address counter.
module tb_playback_ctrl;

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_btn_play = 1'b0;
    logic       i_btn_stop = 1'b0;
    logic       i_btn_rewind = 1'b0;
    logic [3:0] addr = 4'd0;
    logic       o_count_go, o_reset_counter, o_done;
    logic [2:0] o_state;
    int         div = 0;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    playback_ctrl #(
        .ADDR_WIDTH(4),
        .LAST_ADDR(15),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk             (clk),
        .i_reset         (i_reset),
        .i_btn_play      (i_btn_play),
        .i_btn_stop      (i_btn_stop),
        .i_btn_rewind    (i_btn_rewind),
        .i_addr          (addr),
        .o_count_go      (o_count_go),
        .o_reset_counter (o_reset_counter),
        .o_state         (o_state),
        .o_done          (o_done)
    );

    // Counter model: samples its controls once every 8 cycles.
    always @(posedge clk) begin
        if (div == 7) begin
            div <= 0;
            if (o_reset_counter) addr <= 4'd0;
            else if (o_count_go) addr <= addr + 4'd1;
        end else begin
            div <= div + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_addr(input logic [3:0] v, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            if (addr == v) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic test_reset;
        i_reset = 1'b1;
        tick(2);
        checks++;
        if (o_state !== 3'd0) begin
            errors++; $display("FAIL reset_state: got %0d expected 0", o_state);
        end
        checks++;
        if (o_count_go !== 1'b0) begin
            errors++; $display("FAIL reset_go: got %b expected 0", o_count_go);
        end
        checks++;
        if (o_reset_counter !== 1'b0) begin
            errors++; $display("FAIL reset_rstcnt: got %b expected 0", o_reset_counter);
        end
        checks++;
        if (o_done !== 1'b0) begin
            errors++; $display("FAIL reset_done: got %b expected 0", o_done);
        end
        i_reset = 1'b0;
        tick(2);
    endtask

    task automatic test_debounce;
        i_btn_play = 1'b1;
        tick(3);
        i_btn_play = 1'b0;
        tick(10);
        checks++;
        if (o_state !== 3'd0) begin
            errors++; $display("FAIL glitch_state: got %0d expected 0", o_state);
        end
        i_btn_play = 1'b1;
        tick(6);
        checks++;
        if (o_state !== 3'd0) begin
            errors++; $display("FAIL press_early: got %0d expected 0", o_state);
        end
        tick(1);
        checks++;
        if (o_state !== 3'd1) begin
            errors++; $display("FAIL press_state: got %0d expected 1", o_state);
        end
        checks++;
        if (o_count_go !== 1'b1) begin
            errors++; $display("FAIL press_go: got %b expected 1", o_count_go);
        end
        tick(3);
        i_btn_play = 1'b0;
        tick(10);
    endtask

    task automatic test_end_of_playback;
        bit ok;
        wait_addr(4'd15, 200, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL eop_reach: got addr %0d expected 15", addr);
        end
        checks++;
        if (o_count_go !== 1'b0 || o_state !== 3'd1 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL eop_last: got go=%b st=%0d done=%b expected go=0 st=1 done=0",
                     o_count_go, o_state, o_done);
        end
        tick(1);
        checks++;
        if (o_state !== 3'd3 || o_done !== 1'b1) begin
            errors++;
            $display("FAIL eop_enter: got st=%0d done=%b expected st=3 done=1", o_state, o_done);
        end
        tick(1);
        checks++;
        if (o_done !== 1'b0) begin
            errors++; $display("FAIL eop_done_pulse: got %b expected 0", o_done);
        end
        tick(20);
        checks++;
        if (addr !== 4'd15 || o_state !== 3'd3) begin
            errors++;
            $display("FAIL eop_hold: got addr=%0d st=%0d expected addr=15 st=3", addr, o_state);
        end
    endtask

    task automatic test_rewind_from_done;
        bit held = 1'b1;
        bit ok = 1'b0;
        i_btn_rewind = 1'b1;
        tick(7);
        checks++;
        if (o_state !== 3'd4 || o_reset_counter !== 1'b1 || o_count_go !== 1'b0) begin
            errors++;
            $display("FAIL rew_enter: got st=%0d rc=%b go=%b expected st=4 rc=1 go=0",
                     o_state, o_reset_counter, o_count_go);
        end
        for (int i = 0; i < 40; i++) begin
            if (i == 3) i_btn_rewind = 1'b0;
            if (addr == 4'd0) begin
                ok = 1'b1;
                break;
            end
            if (o_reset_counter !== 1'b1) held = 1'b0;
            tick(1);
        end
        i_btn_rewind = 1'b0;
        checks++;
        if (!ok || !held) begin
            errors++; $display("FAIL rew_hold: got ok=%b held=%b expected 1 1", ok, held);
        end
        checks++;
        if (o_state !== 3'd4 || o_reset_counter !== 1'b1) begin
            errors++;
            $display("FAIL rew_zero: got st=%0d rc=%b expected st=4 rc=1", o_state, o_reset_counter);
        end
        tick(1);
        checks++;
        if (o_state !== 3'd0 || o_reset_counter !== 1'b0) begin
            errors++;
            $display("FAIL rew_exit: got st=%0d rc=%b expected st=0 rc=0", o_state, o_reset_counter);
        end
        tick(10);
    endtask

    task automatic test_pause_resume;
        bit ok;
        bit stay = 1'b1;
        i_btn_play = 1'b1;
        tick(7);
        checks++;
        if (o_state !== 3'd1) begin
            errors++; $display("FAIL pr_play: got %0d expected 1", o_state);
        end
        tick(3);
        i_btn_play = 1'b0;
        wait_addr(4'd5, 100, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL pr_reach5: got addr %0d expected 5", addr);
        end
        i_btn_stop = 1'b1;
        tick(7);
        checks++;
        if (o_state !== 3'd2 || addr !== 4'd5) begin
            errors++;
            $display("FAIL pr_pause: got st=%0d addr=%0d expected st=2 addr=5", o_state, addr);
        end
        tick(3);
        i_btn_stop = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (addr !== 4'd5 || o_state !== 3'd2) stay = 1'b0;
            tick(1);
        end
        checks++;
        if (!stay) begin
            errors++; $display("FAIL pr_hold: got stay=%b expected 1", stay);
        end
        i_btn_play = 1'b1;
        tick(7);
        checks++;
        if (o_state !== 3'd1) begin
            errors++; $display("FAIL pr_resume: got %0d expected 1", o_state);
        end
        i_btn_play = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (addr != 4'd5) break;
            tick(1);
        end
        checks++;
        if (addr !== 4'd6) begin
            errors++; $display("FAIL pr_next: got addr %0d expected 6", addr);
        end
    endtask

    task automatic test_simultaneous;
        bit ok = 1'b0;
        i_btn_play = 1'b1;
        i_btn_stop = 1'b1;
        i_btn_rewind = 1'b1;
        tick(7);
        checks++;
        if (o_state !== 3'd4) begin
            errors++; $display("FAIL sim_all: got %0d expected 4", o_state);
        end
        tick(3);
        i_btn_play = 1'b0;
        i_btn_stop = 1'b0;
        i_btn_rewind = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (o_state == 3'd0) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        checks++;
        if (!ok) begin
            errors++; $display("FAIL sim_idle: got %0d expected 0", o_state);
        end
        tick(10);
        i_btn_play = 1'b1;
        tick(7);
        checks++;
        if (o_state !== 3'd1) begin
            errors++; $display("FAIL sim_replay: got %0d expected 1", o_state);
        end
        tick(3);
        i_btn_play = 1'b0;
        wait_addr(4'd3, 100, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL sim_reach3: got addr %0d expected 3", addr);
        end
        i_btn_stop = 1'b1;
        i_btn_play = 1'b1;
        tick(7);
        checks++;
        if (o_state !== 3'd2) begin
            errors++; $display("FAIL sim_stop_play: got %0d expected 2", o_state);
        end
        tick(3);
        i_btn_stop = 1'b0;
        i_btn_play = 1'b0;
        tick(10);
    endtask

    task automatic test_reset_mid_op;
        i_btn_rewind = 1'b1;
        i_btn_play = 1'b1;
        tick(7);
        checks++;
        if (o_state !== 3'd4) begin
            errors++; $display("FAIL rst_rew: got %0d expected 4", o_state);
        end
        i_btn_rewind = 1'b0;
        i_reset = 1'b1;
        tick(1);
        checks++;
        if (o_state !== 3'd0 || o_count_go !== 1'b0 ||
            o_reset_counter !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: got st=%0d go=%b rc=%b done=%b expected all 0",
                     o_state, o_count_go, o_reset_counter, o_done);
        end
        i_reset = 1'b0;
        tick(6);
        checks++;
        if (o_state !== 3'd0) begin
            errors++; $display("FAIL rst_wait: got %0d expected 0", o_state);
        end
        tick(1);
        checks++;
        if (o_state !== 3'd1 || o_count_go !== 1'b1) begin
            errors++;
            $display("FAIL rst_repulse: got st=%0d go=%b expected st=1 go=1", o_state, o_count_go);
        end
        i_btn_play = 1'b0;
        tick(5);
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_end_of_playback();
        test_rewind_from_done();
        test_pause_resume();
        test_simultaneous();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
